// File: rtl/axis_xor_checksum_engine.sv
// AXI-Stream stage: XORs every beat with a 64-bit key and can append one trailer beat
// per packet holding the mod-2^64 sum of the raw input beats. Registers sit on a set/get strobe bus.
module axis_xor_checksum_engine #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
    input  logic                          set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
    input  logic                          get_stb,
    output logic                          busy
);
    localparam int DW = C_AXIS_DATA_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_TRAILER = 2'd2;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_KEY_LO = 3'd1;
    localparam logic [2:0] A_KEY_HI = 3'd2;
    localparam logic [2:0] A_PKT    = 3'd3;
    localparam logic [2:0] A_BEAT   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    logic [1:0]    r_state;
    logic          r_enable;
    logic          r_append;
    logic [DW-1:0] r_key;
    logic          r_append_sh;
    logic [DW-1:0] r_key_sh;
    logic [DW-1:0] r_sum;
    logic [31:0]   r_pkt_count;
    logic [31:0]   r_beat_count;
    logic          r_cfg_mid;
    logic [DW-1:0] r_m_tdata;
    logic          r_m_tlast;
    logic          r_m_tvalid;

    logic          w_load;
    logic          w_accept;
    logic          w_busy;
    logic          w_pkt_done;
    logic [DW-1:0] w_key_eff;
    logic          w_append_eff;
    logic [2:0]    w_set_sel;
    logic [2:0]    w_get_sel;
    logic          w_cfg_write;
    logic          w_unused;

    assign w_load        = !r_m_tvalid || m_axis_tready;
    assign s_axis_tready = r_enable && w_load && (r_state != ST_TRAILER);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_busy        = (r_state != ST_IDLE);
    assign w_pkt_done    = r_m_tvalid && m_axis_tready && r_m_tlast;

    // The first beat of a packet uses the live config; the shadow copy takes over after it.
    assign w_key_eff    = (r_state == ST_IDLE) ? r_key    : r_key_sh;
    assign w_append_eff = (r_state == ST_IDLE) ? r_append : r_append_sh;

    assign w_set_sel   = set_addr[4:2];
    assign w_get_sel   = get_addr[4:2];
    assign w_cfg_write = set_stb && (w_set_sel == A_CTRL || w_set_sel == A_KEY_LO ||
                                     w_set_sel == A_KEY_HI);
    assign w_unused    = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:5], set_addr[1:0],
                           get_addr[C_S_AXI_ADDR_WIDTH-1:5], get_addr[1:0]};

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign busy          = w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key_sh    <= '0;
            r_append_sh <= 1'b0;
            r_sum       <= '0;
            r_m_tdata   <= '0;
            r_m_tlast   <= 1'b0;
            r_m_tvalid  <= 1'b0;
        end else if (w_accept) begin
            r_m_tdata  <= s_axis_tdata ^ w_key_eff;
            r_m_tlast  <= s_axis_tlast && !w_append_eff;
            r_m_tvalid <= 1'b1;
            if (r_state == ST_IDLE) begin
                r_key_sh    <= r_key;
                r_append_sh <= r_append;
                r_sum       <= s_axis_tdata;
            end else begin
                r_sum <= r_sum + s_axis_tdata;
            end
            if (s_axis_tlast) begin
                r_state <= w_append_eff ? ST_TRAILER : ST_IDLE;
            end else begin
                r_state <= ST_PASS;
            end
        end else if (r_state == ST_TRAILER && w_load) begin
            r_m_tdata  <= r_sum;
            r_m_tlast  <= 1'b1;
            r_m_tvalid <= 1'b1;
            r_state    <= ST_IDLE;
        end else if (w_load) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable     <= 1'b0;
            r_append     <= 1'b0;
            r_key        <= '0;
            r_pkt_count  <= '0;
            r_beat_count <= '0;
            r_cfg_mid    <= 1'b0;
        end else begin
            if (set_stb && w_set_sel == A_CTRL) begin
                r_enable <= set_data[0];
                r_append <= set_data[1];
            end
            if (set_stb && w_set_sel == A_KEY_LO) r_key[31:0]  <= set_data[31:0];
            if (set_stb && w_set_sel == A_KEY_HI) r_key[63:32] <= set_data[31:0];

            // A clearing write takes priority over a same-cycle increment.
            if (set_stb && w_set_sel == A_PKT) begin
                r_pkt_count <= '0;
            end else if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (set_stb && w_set_sel == A_BEAT) begin
                r_beat_count <= '0;
            end else if (w_accept) begin
                r_beat_count <= r_beat_count + 32'd1;
            end

            if (w_cfg_write && w_busy) begin
                r_cfg_mid <= 1'b1;
            end else if (get_stb && w_get_sel == A_STATUS) begin
                r_cfg_mid <= 1'b0;
            end
        end
    end

    always_comb begin
        get_data = '0;
        case (w_get_sel)
            A_CTRL:   get_data[1:0] = {r_append, r_enable};
            A_KEY_LO: get_data      = r_key[31:0];
            A_KEY_HI: get_data      = r_key[63:32];
            A_PKT:    get_data      = r_pkt_count;
            A_BEAT:   get_data      = r_beat_count;
            A_STATUS: get_data[1:0] = {r_cfg_mid, w_busy};
            default:  get_data      = '0;
        endcase
    end
endmodule

// File: tb/tb_axis_xor_checksum_engine.sv
// Self-checking bench for axis_xor_checksum_engine: directed table, corner sequences
// and a randomized run scored against a packet-level reference model.
module tb_axis_xor_checksum_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] set_addr;
    logic [31:0] set_data;
    logic        set_stb;
    logic [31:0] get_addr;
    logic [31:0] get_data;
    logic        get_stb;
    logic        busy;

    axis_xor_checksum_engine dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [31:0] ctrl;
        logic [63:0] key;
        logic [63:0] din;
        logic [63:0] exp_d;
        logic        exp_l;
        logic        has_trl;
        logic [63:0] exp_trl;
        logic        exp_busy;
    } vec_t;

    beat_t obs_q[$];
    beat_t exp_q[$];
    beat_t mon_b;
    vec_t  vecs[5];
    int    cmp_cnt = 0;
    int    fail_cnt = 0;
    logic  busy_seen = 1'b0;
    logic  rand_ready = 1'b0;

    // Output monitor: a beat counts as delivered when valid && ready holds at the edge.
    initial forever begin
        @(negedge clk);
        if (m_axis_tvalid && m_axis_tready && !rst) begin
            mon_b.d = m_axis_tdata;
            mon_b.l = m_axis_tlast;
            obs_q.push_back(mon_b);
        end
        if (busy) busy_seen = 1'b1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) m_axis_tready = ($urandom_range(0, 9) < 7);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input string name, input logic [63:0] d, input logic l);
        beat_t b;
        if (obs_q.size() == 0) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL %s: no output beat, want 0x%h last=%0b", name, d, l);
        end else begin
            b = obs_q.pop_front();
            check({name, " data"}, b.d, d);
            check({name, " last"}, {63'd0, b.l}, {63'd0, l});
        end
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        set_addr = a;
        set_data = d;
        set_stb  = 1'b1;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        get_addr = a;
        #1;
        check(name, {32'd0, get_data}, {32'd0, exp});
    endtask

    task automatic clear_sticky();
        get_addr = 32'h14;
        get_stb  = 1'b1;
        tick();
        get_stb  = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL send timeout: s_axis_tready stayed 0 for beat 0x%h", d);
        end
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((m_axis_tvalid || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (m_axis_tvalid || busy) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL drain timeout: valid=%0b busy=%0b, want 0 0", m_axis_tvalid, busy);
        end
        tick();
    endtask

    task automatic set_cfg(input logic [31:0] ctrl, input logic [63:0] key);
        reg_write(32'h04, key[31:0]);
        reg_write(32'h08, key[63:32]);
        reg_write(32'h00, ctrl);
    endtask

    initial begin
        logic [63:0] key, sum;
        logic        app;
        int          len, total_beats;

        vecs[0] = '{32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210, 1'b1, 1'b0, 64'd0, 1'b0};
        vecs[1] = '{32'd3, 64'h0, 64'h5, 64'h5, 1'b0, 1'b1, 64'h5, 1'b1};
        vecs[2] = '{32'd3, 64'hFF, 64'h1234, 64'h12CB, 1'b0, 1'b1, 64'h1234, 1'b1};
        vecs[3] = '{32'd1, 64'hAAAAAAAA_55555555, 64'hFFFFFFFF_00000000, 64'h55555555_55555555, 1'b1, 1'b0, 64'd0, 1'b0};
        vecs[4] = '{32'd3, 64'h80000000_00000000, 64'h80000000_00000001, 64'h1, 1'b0, 1'b1, 64'h80000000_00000001, 1'b1};

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        set_addr = '0; set_data = '0; set_stb = 1'b0;
        get_addr = '0; get_stb = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("reset m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("reset m_tdata", m_axis_tdata, 64'd0);
        check("reset m_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("reset s_tready", {63'd0, s_axis_tready}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        for (int a = 0; a < 8; a++) check_reg("reset reg", a * 4, 32'd0);

        // Append-sum packet 1,2,3
        reg_write(32'h00, 32'd3);
        obs_q.delete();
        send_beat(64'd1, 1'b0);
        send_beat(64'd2, 1'b0);
        send_beat(64'd3, 1'b1);
        drain();
        expect_beat("p1 b0", 64'd1, 1'b0);
        expect_beat("p1 b1", 64'd2, 1'b0);
        expect_beat("p1 b2", 64'd3, 1'b0);
        expect_beat("p1 trailer", 64'd6, 1'b1);
        check("p1 extra beats", obs_q.size(), 64'd0);
        check_reg("p1 PKT_COUNT", 32'h0C, 32'd1);
        check_reg("p1 BEAT_COUNT", 32'h10, 32'd3);
        $display("directed packet 1,2,3 with trailer done");

        // Single-beat table
        for (int i = 0; i < 5; i++) begin
            set_cfg(vecs[i].ctrl, vecs[i].key);
            obs_q.delete();
            busy_seen = 1'b0;
            send_beat(vecs[i].din, 1'b1);
            drain();
            expect_beat($sformatf("vec%0d beat", i), vecs[i].exp_d, vecs[i].exp_l);
            if (vecs[i].has_trl) expect_beat($sformatf("vec%0d trailer", i), vecs[i].exp_trl, 1'b1);
            check($sformatf("vec%0d extra beats", i), obs_q.size(), 64'd0);
            check($sformatf("vec%0d busy seen", i), {63'd0, busy_seen}, {63'd0, vecs[i].exp_busy});
            $display("vec %0d: din 0x%h key 0x%h ctrl %0d", i, vecs[i].din, vecs[i].key, vecs[i].ctrl);
        end

        // Sum wrap and a stalled trailer
        set_cfg(32'd3, 64'd0);
        obs_q.delete();
        send_beat(64'hFFFFFFFF_FFFFFFFF, 1'b0);
        send_beat(64'd2, 1'b1);
        tick();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall trailer data", m_axis_tdata, 64'd1);
            check("stall trailer valid/last/s_tready",
                  {61'd0, m_axis_tvalid, m_axis_tlast, s_axis_tready}, 64'b110);
        end
        tick();
        m_axis_tready = 1'b1;
        drain();
        expect_beat("wrap b0", 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        expect_beat("wrap b1", 64'd2, 1'b0);
        expect_beat("wrap trailer", 64'd1, 1'b1);
        $display("wrap/stall packet done");

        // Config write mid-packet
        set_cfg(32'd1, 64'd0);
        clear_sticky();
        obs_q.delete();
        send_beat(64'h10, 1'b0);
        reg_write(32'h04, 32'hFF);
        check_reg("mid STATUS busy", 32'h14, 32'h3);
        send_beat(64'h20, 1'b1);
        drain();
        check_reg("mid STATUS idle", 32'h14, 32'h2);
        clear_sticky();
        check_reg("mid STATUS cleared", 32'h14, 32'h0);
        send_beat(64'h0F, 1'b1);
        drain();
        expect_beat("mid b0", 64'h10, 1'b0);
        expect_beat("mid b1", 64'h20, 1'b1);
        expect_beat("mid next pkt", 64'hF0, 1'b1);
        $display("mid-packet config write done");

        // Randomized packets against the reference model
        reg_write(32'h0C, 32'd0);
        reg_write(32'h10, 32'd0);
        obs_q.delete();
        exp_q.delete();
        total_beats = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < 50; p++) begin
            key = {$urandom, $urandom};
            app = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 39);
            set_cfg({30'd0, app, 1'b1}, key);
            sum = 64'd0;
            for (int b = 0; b < len; b++) begin
                beat_t e;
                logic [63:0] d;
                d = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                send_beat(d, (b == len - 1));
                sum = sum + d;
                e.d = d ^ key;
                e.l = (b == len - 1) && !app;
                exp_q.push_back(e);
            end
            if (app) begin
                beat_t t;
                t.d = sum;
                t.l = 1'b1;
                exp_q.push_back(t);
            end
            total_beats += len;
            $display("random pkt %0d: len %0d append %0b key 0x%h", p, len, app, key);
        end
        drain();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        check("random beat count", obs_q.size(), exp_q.size());
        for (int k = 0; exp_q.size() > 0; k++) begin
            beat_t e;
            e = exp_q.pop_front();
            expect_beat($sformatf("random beat %0d", k), e.d, e.l);
        end
        check_reg("random PKT_COUNT", 32'h0C, 32'd50);
        check_reg("random BEAT_COUNT", 32'h10, total_beats);

        // Reset in the middle of a packet
        set_cfg(32'd3, 64'd0);
        send_beat(64'hA, 1'b0);
        send_beat(64'hB, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check_reg("rst PKT_COUNT", 32'h0C, 32'd0);
        check_reg("rst BEAT_COUNT", 32'h10, 32'd0);
        check_reg("rst CTRL", 32'h00, 32'd0);
        obs_q.delete();
        reg_write(32'h00, 32'd3);
        send_beat(64'd7, 1'b0);
        send_beat(64'd8, 1'b1);
        drain();
        repeat (5) tick();
        expect_beat("post-rst b0", 64'd7, 1'b0);
        expect_beat("post-rst b1", 64'd8, 1'b0);
        expect_beat("post-rst trailer", 64'd15, 1'b1);
        check("post-rst extra beats", obs_q.size(), 64'd0);
        $display("reset mid-packet done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
